// File: rtl/harness_pkg.sv
// harness_pkg
//   Shared definitions for the memory self-test harness:
//   - state_t     : self-test FSM states
//   - DEF_*       : default word width, LFSR seed and LFSR feedback taps
//   - lfsr_next() : one Galois LFSR step on a word of up to 64 bits
package harness_pkg;

  localparam int          DEF_DATA_W    = 32;
  localparam logic [31:0] DEF_LFSR_SEED = 32'h0000_0001;
  localparam logic [31:0] DEF_LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } state_t;

  // Operates on a 64-bit container so one function serves every word width up
  // to 64. With the value and taps zero-extended, the right shift and XOR never
  // set bits above the real width, so the caller simply truncates the result.
  function automatic logic [63:0] lfsr_next(input logic [63:0] value,
                                            input logic [63:0] poly);
    return value[0] ? ((value >> 1) ^ poly) : (value >> 1);
  endfunction

endpackage

// File: rtl/harness_sram.sv
// harness_sram
//   Single-port synchronous scratchpad RAM with a registered read port.
//   The array has no reset; only the read-data register's contents matter.
// Ports
//   clk    in            rising-edge clock
//   we     in            write enable for mem[addr]
//   addr   in  [AW-1:0]  word address (read and write)
//   wdata  in  [DW-1:0]  write data
//   rdata  out [DW-1:0]  mem[addr] as sampled on the previous rising edge
module harness_sram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/test_harness.sv
// test_harness
//   Built-in memory self-test. After reset, the harness writes an LFSR pattern
//   into a scratchpad, then reads it back and compares every word against the
//   regenerated pattern. A full pass raises io_success; any mismatch parks the
//   FSM in FAIL with io_success low until the next reset.
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high; aborts and restarts the test
//   io_success  out  registered; high once every word has compared equal
module test_harness
  import harness_pkg::*;
#(
  parameter int                DEPTH       = 256,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter logic [DATA_W-1:0] LFSR_SEED   = DATA_W'(DEF_LFSR_SEED),
  parameter logic [DATA_W-1:0] LFSR_POLY   = DATA_W'(DEF_LFSR_POLY),
  parameter int                INJECT_ADDR = -1
) (
  input  logic clk,
  input  logic reset,
  output logic io_success
);

  localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t            state_reg;
  logic [AW-1:0]     addr_reg;
  logic [DATA_W-1:0] lfsr_reg;
  logic [DATA_W-1:0] exp_reg;        // expected word for the read now in flight
  logic              cmp_valid_reg;  // rdata holds a word to compare this edge
  logic              cmp_last_reg;   // ...and it is the final word
  logic              rd_done_reg;    // all reads issued; only the last compare remains
  logic              success_reg;

  logic [DATA_W-1:0] lfsr_step;
  logic              inject_hit;
  logic              issue_rd;
  logic              sram_we;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  assign lfsr_step = DATA_W'(lfsr_next(64'(lfsr_reg), 64'(LFSR_POLY)));

  // Deliberate fault: flip bit 0 of one word on its way into the RAM.
  assign inject_hit = (INJECT_ADDR >= 0) && (INJECT_ADDR < DEPTH) &&
                      (int'(addr_reg) == INJECT_ADDR);

  assign sram_we    = (state_reg == WRITE);
  assign sram_wdata = lfsr_reg ^ {{(DATA_W-1){1'b0}}, inject_hit};
  assign issue_rd   = (state_reg == READ) && !rd_done_reg;

  harness_sram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .addr  (addr_reg),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      lfsr_reg      <= LFSR_SEED;
      exp_reg       <= '0;
      cmp_valid_reg <= 1'b0;
      cmp_last_reg  <= 1'b0;
      rd_done_reg   <= 1'b0;
      success_reg   <= 1'b0;
    end else begin
      cmp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          state_reg <= WRITE;
          addr_reg  <= '0;
        end
        WRITE: begin
          lfsr_reg <= lfsr_step;
          addr_reg <= addr_reg + 1'b1;
          // Phase change keys on the last address, not on counter overflow.
          if (addr_reg == LAST_ADDR) begin
            state_reg <= READ;
            addr_reg  <= '0;
            lfsr_reg  <= LFSR_SEED;
          end
        end
        READ: begin
          if (issue_rd) begin
            // The expected word travels alongside the 1-cycle RAM read.
            exp_reg       <= lfsr_reg;
            cmp_valid_reg <= 1'b1;
            cmp_last_reg  <= (addr_reg == LAST_ADDR);
            lfsr_reg      <= lfsr_step;
            addr_reg      <= addr_reg + 1'b1;
            if (addr_reg == LAST_ADDR) begin
              addr_reg    <= '0;
              rd_done_reg <= 1'b1;
            end
          end
          // Comparator placed last so its verdict overrides the read bookkeeping.
          if (cmp_valid_reg) begin
            if (sram_rdata != exp_reg) begin
              state_reg <= FAIL;
            end else if (cmp_last_reg) begin
              state_reg   <= DONE;
              success_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          success_reg <= 1'b1;
        end
        FAIL: begin
          success_reg <= 1'b0;
        end
        default: begin
          state_reg <= FAIL;
        end
      endcase
    end
  end

  assign io_success = success_reg;

endmodule

// File: tb/tb_test_harness.sv
// tb_test_harness
//   Directed bench for test_harness. Four instances run side by side:
//     dut_a   : defaults (DEPTH=256), owns reset_a for the restart scenarios
//     dut_d4  : DEPTH=4
//     dut_i17 : INJECT_ADDR=17
//     dut_i255: INJECT_ADDR=255 (fault on the final word)
//   The last three share reset_b. Edges are counted from the first rising
//   edge with reset low; outputs are sampled 1 time unit after each edge.
module tb_test_harness;

  logic clk;
  logic reset_a;
  logic reset_b;
  logic succ_a;
  logic succ_d4;
  logic succ_i17;
  logic succ_i255;

  int vectors;
  int miscompares;

  test_harness dut_a (
    .clk        (clk),
    .reset      (reset_a),
    .io_success (succ_a)
  );

  test_harness #(.DEPTH(4)) dut_d4 (
    .clk        (clk),
    .reset      (reset_b),
    .io_success (succ_d4)
  );

  test_harness #(.INJECT_ADDR(17)) dut_i17 (
    .clk        (clk),
    .reset      (reset_b),
    .io_success (succ_i17)
  );

  test_harness #(.INJECT_ADDR(255)) dut_i255 (
    .clk        (clk),
    .reset      (reset_b),
    .io_success (succ_i255)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance n edges on dut_a only, expecting io_success to rise on edge 'rise'.
  task automatic run_a(input string tag, input int n, input int rise);
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s e%0d", tag, e), {31'b0, succ_a},
            (e >= rise) ? 32'd1 : 32'd0);
    end
  endtask

  logic [31:0] mem4_exp [4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    mem4_exp[0] = 32'h0000_0001;
    mem4_exp[1] = 32'h8020_0003;
    mem4_exp[2] = 32'hC030_0002;
    mem4_exp[3] = 32'h6018_0001;

    // Reset state
    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset succ_a",    {31'b0, succ_a},    32'd0);
    check("reset succ_d4",   {31'b0, succ_d4},   32'd0);
    check("reset succ_i17",  {31'b0, succ_i17},  32'd0);
    check("reset succ_i255", {31'b0, succ_i255}, 32'd0);
    $display("step reset: vectors=%0d miscompares=%0d", vectors, miscompares);
    reset_a = 1'b0;
    reset_b = 1'b0;

    // Tests 1,2,3,6 in parallel: default pass at 514 and held, DEPTH=4 pass
    // at 10, both injected faults never pass (2100 edges).
    for (int e = 1; e <= 2100; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("t1 default e%0d", e), {31'b0, succ_a},
            (e >= 514) ? 32'd1 : 32'd0);
      check($sformatf("t2 depth4 e%0d", e), {31'b0, succ_d4},
            (e >= 10) ? 32'd1 : 32'd0);
      check($sformatf("t3 inject17 e%0d", e), {31'b0, succ_i17}, 32'd0);
      check($sformatf("t6 inject255 e%0d", e), {31'b0, succ_i255}, 32'd0);
    end
    $display("step t1/t2/t3/t6 run: vectors=%0d miscompares=%0d", vectors, miscompares);

    // Test 2: scratchpad contents of the DEPTH=4 instance
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2 mem[%0d]", i), dut_d4.u_sram.mem[i], mem4_exp[i]);
    end
    $display("step t2 mem: vectors=%0d miscompares=%0d", vectors, miscompares);

    // Test 4: restart, then abort during READ at edge 300 for 3 edges
    reset_a = 1'b1;
    @(posedge clk);
    #1;
    check("t4 pre-reset", {31'b0, succ_a}, 32'd0);
    reset_a = 1'b0;
    run_a("t4 before abort", 299, 514);
    reset_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t4 at release", {31'b0, succ_a}, 32'd0);
    reset_a = 1'b0;
    run_a("t4 after release", 520, 514);
    $display("step t4: vectors=%0d miscompares=%0d", vectors, miscompares);

    // Test 5: reset while in DONE, then a full rerun
    reset_a = 1'b1;
    @(posedge clk);
    #1;
    check("t5 reset from DONE", {31'b0, succ_a}, 32'd0);
    reset_a = 1'b0;
    run_a("t5 rerun", 620, 514);
    $display("step t5: vectors=%0d miscompares=%0d", vectors, miscompares);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
